// File: rtl/ref_clk_training_ctrl.sv
`timescale 1ns/1ps
// ref_clk_training_ctrl
// Fabric-side training controller for the reference-clock (DDR3 CK0 loop-back)
// training IOD lane. Sweeps the input delay one tap at a time, classifying each
// tap from the deserialized RX words and eye-monitor flags, and reports the
// first tap where the sampled reference clock goes cleanly from 0 to 1.
//
// Ports:
//   FAB_CLK                  fabric clock (same as IOD RX_CLK)
//   RESET                    synchronous active-high reset
//   TRAIN_START              single-cycle start request, ignored while BUSY
//   RX_DATA[7:0]             deserialized word, bit 0 earliest
//   EYE_MONITOR_EARLY/LATE   sticky eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE  IOD delay line at its limit
//   DELAY_LINE_LOAD          pulse: reload delay to tap 0
//   DELAY_LINE_MOVE          pulse: step delay one tap
//   DELAY_LINE_DIRECTION     1 = increment, high whenever BUSY
//   EYE_MONITOR_CLEAR_FLAGS  pulse: clear IOD eye flags
//   BUSY                     training in progress
//   TRAIN_DONE / TRAIN_FAIL  sticky result levels
//   EDGE_TAP[7:0]            tap of the 0->1 transition, valid with TRAIN_DONE
//
// Timing: with TRAIN_START sampled at edge 0, TRAIN_DONE/TRAIN_FAIL rise (and
// BUSY falls) at edge 1 + (k+1)*(SETTLE_CYCLES+NUM_SAMPLES+2) + k, where k is
// the tap evaluated last.
module ref_clk_training_ctrl #(
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned NUM_SAMPLES   = 16
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_FAIL,
    output logic [7:0] EDGE_TAP
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [7:0]       TAP_LAST    = 8'(MAX_TAPS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CLEAR,
        S_SAMPLE,
        S_EVAL,
        S_MOVE,
        S_DONE,
        S_FAIL
    } state_e;

    typedef enum logic [1:0] {
        C_NONE,
        C_ZERO,
        C_ONE,
        C_UNSTABLE
    } class_e;

    state_e           state_q;
    class_e           prev_q;
    class_e           curr_c;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       tap_q;
    logic             ones_q;
    logic             zeros_q;
    logic             eye_q;
    logic             load_q;
    logic             move_q;
    logic             clear_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;
    logic [7:0]       edge_tap_q;

    // Classification of the tap just sampled; any eye flag vetoes a stable level.
    always_comb begin
        curr_c = C_UNSTABLE;
        if (!eye_q && ones_q) begin
            curr_c = C_ONE;
        end else if (!eye_q && zeros_q) begin
            curr_c = C_ZERO;
        end
    end

    // Training sequencer with registered pulses and status.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            prev_q     <= C_NONE;
            cnt_q      <= '0;
            tap_q      <= '0;
            ones_q     <= 1'b0;
            zeros_q    <= 1'b0;
            eye_q      <= 1'b0;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            edge_tap_q <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            load_q  <= 1'b0;
            move_q  <= 1'b0;
            clear_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    tap_q  <= '0;
                    prev_q <= C_NONE;
                    if (TRAIN_START) begin
                        state_q    <= S_LOAD;
                        load_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        edge_tap_q <= '0;
                    end
                end

                S_LOAD: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= '0;
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= S_CLEAR;
                        clear_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // Flags are cleared here so only this tap's sampling window counts.
                S_CLEAR: begin
                    state_q <= S_SAMPLE;
                    ones_q  <= 1'b1;
                    zeros_q <= 1'b1;
                    eye_q   <= 1'b0;
                    cnt_q   <= '0;
                end

                S_SAMPLE: begin
                    ones_q  <= ones_q  & (RX_DATA == 8'hFF);
                    zeros_q <= zeros_q & (RX_DATA == 8'h00);
                    eye_q   <= eye_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
                    if (cnt_q == SAMPLE_LAST) begin
                        state_q <= S_EVAL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // An edge needs a clean ZERO tap immediately before a clean ONE tap.
                S_EVAL: begin
                    if ((prev_q == C_ZERO) && (curr_c == C_ONE)) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        edge_tap_q <= tap_q;
                    end else if (DELAY_LINE_OUT_OF_RANGE || (tap_q == TAP_LAST)) begin
                        state_q <= S_FAIL;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        prev_q  <= curr_c;
                        state_q <= S_MOVE;
                        move_q  <= 1'b1;
                    end
                end

                S_MOVE: begin
                    tap_q   <= tap_q + 8'd1;
                    state_q <= S_SETTLE;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = busy_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
    assign BUSY                    = busy_q;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_FAIL              = fail_q;
    assign EDGE_TAP                = edge_tap_q;

endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
`timescale 1ns/1ps
// Bench for ref_clk_training_ctrl: an IOD model follows LOAD/MOVE pulses to
// present per-tap RX data and eye flags; expected outcomes are queued at start
// and compared when the sweep finishes.
module tb_ref_clk_training_ctrl;

    localparam int S   = 8;
    localparam int N   = 16;
    localparam int PER = S + N + 2;

    typedef struct {
        logic       done;
        logic       fail;
        logic [7:0] tap;
        int         loads;
        int         moves;
        int         clears;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start8;
    logic [7:0] rx;
    logic       early, late, oor;

    logic       load, move, dir, clr, busy, done, fail;
    logic [7:0] etap;
    logic       load8, move8, dir8, clr8, busy8, done8, fail8;
    logic [7:0] etap8;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;
    int   mtap  = 0;
    bit   tog   = 1'b0;
    bit   late_f  = 1'b0;
    bit   early_f = 1'b0;
    int   c_load, c_move, c_clear, c8_load, c8_move, c8_clear;
    int   viol = 0;

    always #5 clk = ~clk;

    ref_clk_training_ctrl dut (
        .FAB_CLK(clk), .RESET(rst), .TRAIN_START(start), .RX_DATA(rx),
        .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dir),
        .EYE_MONITOR_CLEAR_FLAGS(clr), .BUSY(busy), .TRAIN_DONE(done),
        .TRAIN_FAIL(fail), .EDGE_TAP(etap)
    );

    ref_clk_training_ctrl #(.MAX_TAPS(8)) dut8 (
        .FAB_CLK(clk), .RESET(rst), .TRAIN_START(start8), .RX_DATA(rx),
        .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_LOAD(load8), .DELAY_LINE_MOVE(move8), .DELAY_LINE_DIRECTION(dir8),
        .EYE_MONITOR_CLEAR_FLAGS(clr8), .BUSY(busy8), .TRAIN_DONE(done8),
        .TRAIN_FAIL(fail8), .EDGE_TAP(etap8)
    );

    // IOD model and pulse monitor, evaluated on the falling edge.
    initial begin
        rx = 8'h00; early = 1'b0; late = 1'b0; oor = 1'b0;
        c_load = 0; c_move = 0; c_clear = 0; c8_load = 0; c8_move = 0; c8_clear = 0;
        forever begin
            @(negedge clk);
            if (load)  c_load++;
            if (move)  c_move++;
            if (clr)   c_clear++;
            if (load8) c8_load++;
            if (move8) c8_move++;
            if (clr8)  c8_clear++;
            if ((int'(load) + int'(move) + int'(clr)) > 1)    viol++;
            if ((int'(load8) + int'(move8) + int'(clr8)) > 1) viol++;
            if (done && fail)   viol++;
            if (done8 && fail8) viol++;
            if (busy !== dir)   viol++;
            if (busy8 !== dir8) viol++;
            if (!done && (etap !== 8'h00))   viol++;
            if (!done8 && (etap8 !== 8'h00)) viol++;

            if (load) mtap = 0;
            else if (move) mtap++;
            tog = ~tog;
            if (clr) begin
                late_f  = 1'b0;
                early_f = 1'b0;
            end
            if (mode == 2 && mtap == 2) late_f  = 1'b1;
            if (mode == 5 && mtap == 2) early_f = 1'b1;

            case (mode)
                0: rx = (mtap < 5) ? 8'h00 : 8'hFF;
                1: begin
                    if (mtap == 0)      rx = 8'h00;
                    else if (mtap <= 2) rx = tog ? 8'hFF : 8'h00;
                    else if (mtap == 3) rx = 8'hFF;
                    else if (mtap == 4) rx = 8'h00;
                    else                rx = 8'hFF;
                end
                2, 5: begin
                    if (mtap <= 1)      rx = 8'h00;
                    else if (mtap <= 3) rx = 8'hFF;
                    else if (mtap == 4) rx = 8'h00;
                    else                rx = 8'hFF;
                end
                3: rx = 8'hFF;
                default: rx = 8'h00;
            endcase
            late  = late_f;
            early = early_f;
            oor   = (mode == 4) && (mtap >= 3);
        end
    end

    function automatic int exp_cycles(input int k);
        return 1 + (k + 1) * PER + k;
    endfunction

    // One training run: queue expectation, start, wait for result, compare.
    task automatic run(input string name, input int sel, input int m, input exp_t e,
                       input int extra_at);
        exp_t got_e;
        int   cyc;
        logic d, f, b, l;
        logic [7:0] t;
        mode = m;
        sb_q.push_back(e);
        c_load = 0; c_move = 0; c_clear = 0; c8_load = 0; c8_move = 0; c8_clear = 0;
        @(negedge clk);
        if (sel == 1) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        cyc = 0;
        b = sel ? busy8 : busy; d = sel ? done8 : done; f = sel ? fail8 : fail;
        l = sel ? load8 : load; t = sel ? etap8 : etap;
        total++;
        if ({b, d, f, l, t} !== {4'b1001, 8'h00}) begin
            bad++;
            $display("FAIL %s start: busy/done/fail/load/tap=%b %b %b %b %0d want 1 0 0 1 0",
                     name, b, d, f, l, t);
        end
        while (!((sel ? done8 : done) || (sel ? fail8 : fail)) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (sel == 0) && (cyc == extra_at);
        end
        start = 1'b0;
        b = sel ? busy8 : busy; d = sel ? done8 : done; f = sel ? fail8 : fail;
        t = sel ? etap8 : etap;
        got_e = sb_q.pop_front();
        total++;
        if (cyc !== got_e.cycles) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, got_e.cycles);
        end
        total++;
        if ({d, f, b} !== {got_e.done, got_e.fail, 1'b0}) begin
            bad++;
            $display("FAIL %s result: done/fail/busy=%b%b%b want %b%b0", name, d, f, b,
                     got_e.done, got_e.fail);
        end
        total++;
        if (t !== got_e.tap) begin
            bad++;
            $display("FAIL %s edge_tap: got %0d want %0d", name, t, got_e.tap);
        end
        repeat (4) @(negedge clk);
        d = sel ? done8 : done; f = sel ? fail8 : fail;
        total++;
        if ({d, f} !== {got_e.done, got_e.fail}) begin
            bad++;
            $display("FAIL %s held: done/fail=%b%b want %b%b", name, d, f, got_e.done, got_e.fail);
        end
        total++;
        if ((sel ? c8_load : c_load) !== got_e.loads) begin
            bad++;
            $display("FAIL %s loads: got %0d want %0d", name, sel ? c8_load : c_load, got_e.loads);
        end
        total++;
        if ((sel ? c8_move : c_move) !== got_e.moves) begin
            bad++;
            $display("FAIL %s moves: got %0d want %0d", name, sel ? c8_move : c_move, got_e.moves);
        end
        total++;
        if ((sel ? c8_clear : c_clear) !== got_e.clears) begin
            bad++;
            $display("FAIL %s clears: got %0d want %0d", name, sel ? c8_clear : c_clear,
                     got_e.clears);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL %s invariants: got %0d violations want 0", name, viol);
        end
    endtask

    function automatic exp_t mk(input logic d, input logic f, input int tap, input int k);
        exp_t e;
        e.done = d; e.fail = f; e.tap = 8'(tap);
        e.loads = 1; e.moves = k; e.clears = k + 1; e.cycles = exp_cycles(k);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c_load = 0; c_move = 0; c_clear = 0; c8_load = 0; c8_move = 0; c8_clear = 0;
        total++;
        if ({load, move, dir, clr, busy, done, fail, etap} !== 15'h0) begin
            bad++;
            $display("FAIL reset outputs: got %h want 0",
                     {load, move, dir, clr, busy, done, fail, etap});
        end
        total++;
        if ({load8, move8, dir8, clr8, busy8, done8, fail8, etap8} !== 15'h0) begin
            bad++;
            $display("FAIL reset outputs8: got %h want 0",
                     {load8, move8, dir8, clr8, busy8, done8, fail8, etap8});
        end
        repeat (5) @(negedge clk);
        total++;
        if ((c_load + c_move + c_clear + c8_load + c8_move + c8_clear) !== 0) begin
            bad++;
            $display("FAIL reset idle pulses: got %0d want 0",
                     c_load + c_move + c_clear + c8_load + c8_move + c8_clear);
        end
    endtask

    task automatic test_edge_found();
        run("edge_found", 0, 0, mk(1'b1, 1'b0, 5, 5), 0);
    endtask

    task automatic test_unstable();
        run("unstable", 0, 1, mk(1'b1, 1'b0, 5, 5), 0);
    endtask

    task automatic test_eye_veto();
        run("eye_late", 0, 2, mk(1'b1, 1'b0, 5, 5), 0);
        run("eye_early", 0, 5, mk(1'b1, 1'b0, 5, 5), 0);
    endtask

    task automatic test_exhaustion();
        run("exhaust", 1, 3, mk(1'b0, 1'b1, 0, 7), 0);
    endtask

    task automatic test_out_of_range();
        run("oor", 0, 4, mk(1'b0, 1'b1, 0, 3), 0);
    endtask

    task automatic test_reset_mid_sample();
        int w;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (mtap != 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (mtap != 2) begin
            bad++;
            $display("FAIL mid_reset reach_tap2: got %0d want 2", mtap);
        end
        repeat (S + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({load, move, dir, clr, busy, done, fail, etap} !== 15'h0) begin
            bad++;
            $display("FAIL mid_reset outputs: got %h want 0",
                     {load, move, dir, clr, busy, done, fail, etap});
        end
        c_load = 0; c_move = 0; c_clear = 0;
        repeat (40) @(negedge clk);
        total++;
        if ({c_load, c_move, c_clear} !== {32'd0, 32'd0, 32'd0} || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset quiet: got load=%0d move=%0d clear=%0d busy=%b want 0 0 0 0",
                     c_load, c_move, c_clear, busy);
        end
    endtask

    task automatic test_back_to_back();
        // Start pulse mid-sweep is ignored; start on the DONE-entry edge is ignored.
        run("busy_ignore", 0, 0, mk(1'b1, 1'b0, 5, 5), 30);
        run("restart", 0, 0, mk(1'b1, 1'b0, 5, 5), exp_cycles(5) - 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        test_reset();
        test_edge_found();
        test_unstable();
        test_eye_veto();
        test_exhaustion();
        test_out_of_range();
        test_reset_mid_sample();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
